oversample_voter: RTL and testbench
===================================

OVERSAMPLE_VOTER -- requirements
Module: oversample_voter

Interface
REQ-001 Parameters SHALL be, one per line:
- PRESCALE_W, 6, width of Prescale and Edge_count.
- SAMPLES, 3, number of votes per bit; legal values are 3 and 5 only (elaboration error otherwise).
- SYNC_STAGES, 2, depth of the RX_IN synchroniser; legal range 1..4.

REQ-002 Ports SHALL be, one per line, clock and reset first:
- Clk, in, 1: the single clock; all state changes on the rising edge.
- Rst, in, 1: asynchronous, active-high reset.
- Prescale, in, PRESCALE_W: oversampling ratio (clocks per bit).
- Edge_count, in, PRESCALE_W: external position within the bit, counting 0..Prescale-1.
- Sample_en, in, 1: sampling permitted while high.
- RX_IN, in, 1: raw asynchronous serial line.
- Sampled_bit, out, 1: majority-voted bit value, held between decisions.
- Sample_valid, out, 1: one-cycle pulse when Sampled_bit updates.
- Noise_err, out, 1: set when the votes of the latest decision were not unanimous.
- Cfg_err, out, 1: Prescale is illegal for SAMPLES.

Function
REQ-003 RX_IN SHALL pass through SYNC_STAGES flops (reset value 1); all votes SHALL use the synchroniser output rx_s.
REQ-004 Definitions: H = (SAMPLES-1)/2; C = floor(Prescale/2); the sampling window is Edge_count = C-H .. C+H inclusive.
REQ-005 Cfg_err SHALL be combinational and equal 1 iff Prescale < 2*H+2.
REQ-006 While Cfg_err = 1, no vote SHALL be captured and Sample_valid SHALL stay 0.
REQ-007 A vote SHALL be captured on each cycle where Sample_en = 1, Cfg_err = 0 and Edge_count lies in the window; vote k goes to index k.
REQ-008 The vote index SHALL be a counter of width clog2(SAMPLES+1).
REQ-009 On the cycle Edge_count = C+H with a capture, and the index equal to SAMPLES-1, the decision SHALL be formed from the stored votes plus the current rx_s.
REQ-010 Decision outputs SHALL be registered on that same edge, so they are visible in the following cycle (latency 1 from the last window edge):
- Sampled_bit = 1 iff at least H+1 votes are 1.
- Sample_valid = 1 for exactly one cycle.
- Noise_err = 1 iff the votes are not all equal.
REQ-011 Noise_err and Sampled_bit SHALL hold their values until the next decision.
REQ-012 The vote index SHALL clear to 0:
- after a decision;
- on any cycle with Sample_en = 0;
- when Edge_count = 0.
REQ-013 A window left incomplete (index < SAMPLES-1 at Edge_count = C+H, Edge_count jumps, or Sample_en drops) SHALL produce no Sample_valid; its partial votes SHALL be discarded.
REQ-014 A change of Prescale mid-window SHALL take effect immediately in the window comparison; correctness of the window in progress is not required, but no more than one Sample_valid per bit period SHALL occur.
REQ-015 Prescale width SHALL bound all arithmetic; C-H and C+H SHALL be computed at PRESCALE_W+1 bits with no wrap-around when Cfg_err = 0.

Reset
REQ-016 On Rst = 1, asynchronously, the following SHALL take these values:
- synchroniser flops: 1;
- vote storage: 0;
- index: 0;
- Sampled_bit: 1 (line-idle value);
- Sample_valid: 0;
- Noise_err: 0.
REQ-017 Reset asserted mid-window SHALL discard all votes; after release, the first decision SHALL require a complete new window.

Verification
REQ-018 SAMPLES=3, SYNC_STAGES=2, Prescale=8, Sample_en=1:
- rx_s = 1,0,1 at Edge_count 3,4,5 -> cycle after Edge_count=5: Sampled_bit=1, Sample_valid=1 for one cycle, Noise_err=1.
REQ-019 SAMPLES=5, Prescale=32:
- rx_s = 0 at Edge_count 14..18 -> Sampled_bit=0, Noise_err=0, Sample_valid pulse after Edge_count=18.
- rx_s = 1,1,0,0,0 over the same window -> Sampled_bit=0, Noise_err=1.
REQ-020 SAMPLES=3, Prescale=3 -> Cfg_err=1; sweep Edge_count 0..2 repeatedly -> Sample_valid never asserts. Then Prescale=4 -> Cfg_err=0; window 1..3; valid after Edge_count=3.
REQ-021 Prescale=16, SAMPLES=3:
- Sample_en drops at Edge_count=8 -> no Sample_valid for that bit.
- Next full window 7..9 with rx_s = 0,0,1 -> Sampled_bit=0, Noise_err=1.
REQ-022 Reset and synchroniser checks:
- Rst pulsed at Edge_count=4 (Prescale=8) after one vote -> outputs return to 1/0/0; no Sample_valid in that bit; the next full window decides normally.
- SYNC_STAGES=3: an RX_IN step appears at rx_s exactly 3 cycles later.

Source files
------------

// File: rtl/oversample_voter_if.sv
// Bundles the oversample voter's line, timing and decision signals.
// The master side drives timing and the raw line; the slave side returns the vote results.
interface oversample_voter_if #(
  parameter int unsigned PRESCALE_W = 6
);
  logic [PRESCALE_W-1:0] Prescale;
  logic [PRESCALE_W-1:0] Edge_count;
  logic                  Sample_en;
  logic                  RX_IN;
  logic                  Sampled_bit;
  logic                  Sample_valid;
  logic                  Noise_err;
  logic                  Cfg_err;

  modport master (
    output Prescale, Edge_count, Sample_en, RX_IN,
    input  Sampled_bit, Sample_valid, Noise_err, Cfg_err
  );

  modport slave (
    input  Prescale, Edge_count, Sample_en, RX_IN,
    output Sampled_bit, Sample_valid, Noise_err, Cfg_err
  );
endinterface

// File: rtl/oversample_voter.sv
// Majority voter for an oversampled serial line.
// It takes SAMPLES votes centred on mid-bit and registers the majority value and a noise flag.
module oversample_voter #(
  parameter int unsigned PRESCALE_W  = 6,
  parameter int unsigned SAMPLES     = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  oversample_voter_if.slave bus
);

  localparam int unsigned H     = (SAMPLES - 1) / 2;
  localparam int unsigned IDX_W = $clog2(SAMPLES + 1);
  localparam int unsigned EW    = PRESCALE_W + 1;

  if (!(SAMPLES == 3 || SAMPLES == 5)) begin : gen_bad_samples
    $error("oversample_voter: SAMPLES must be 3 or 5");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : gen_bad_sync
    $error("oversample_voter: SYNC_STAGES must be 1..4");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;
  logic [EW-1:0]          ctr, win_lo, win_hi, ec_w;
  logic                   cfg_err, in_win, capture, at_hi, decide;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SAMPLES-2:0]     votes_q, votes_d;
  logic [SAMPLES-1:0]     votes_all;
  logic [IDX_W-1:0]       ones;
  logic                   bit_q, bit_d, valid_q, noise_q, noise_d;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = bus.RX_IN;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Window arithmetic is one bit wider than Prescale so C+H never wraps.
  assign ec_w    = {1'b0, bus.Edge_count};
  assign ctr     = {1'b0, bus.Prescale} >> 1;
  assign win_lo  = ctr - EW'(H);
  assign win_hi  = ctr + EW'(H);
  assign cfg_err = {1'b0, bus.Prescale} < EW'(2 * H + 2);
  assign in_win  = (ec_w >= win_lo) && (ec_w <= win_hi);
  assign capture = bus.Sample_en && !cfg_err && in_win;
  assign at_hi   = (ec_w == win_hi);
  assign decide  = capture && at_hi && (idx_q == IDX_W'(SAMPLES - 1));

  // Any cycle that does not extend the window restarts it, discarding partial votes.
  always_comb begin
    idx_d   = '0;
    votes_d = votes_q;
    if (capture && !at_hi && (bus.Edge_count != '0)) begin
      idx_d = (idx_q == IDX_W'(SAMPLES)) ? idx_q : idx_q + IDX_W'(1);
      for (int k = 0; k < SAMPLES - 1; k++) begin
        if (idx_q == IDX_W'(k)) votes_d[k] = rx_s;
      end
    end
  end

  assign votes_all = {rx_s, votes_q};

  always_comb begin
    ones = '0;
    for (int k = 0; k < SAMPLES; k++) begin
      ones = ones + IDX_W'(votes_all[k]);
    end
  end

  always_comb begin
    bit_d   = bit_q;
    noise_d = noise_q;
    if (decide) begin
      bit_d   = (ones >= IDX_W'(H + 1));
      noise_d = (ones != '0) && (ones != IDX_W'(SAMPLES));
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_q  <= '1;
      votes_q <= '0;
      idx_q   <= '0;
      bit_q   <= 1'b1;
      valid_q <= 1'b0;
      noise_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      votes_q <= votes_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      valid_q <= decide;
      noise_q <= noise_d;
    end
  end

  assign bus.Sampled_bit  = bit_q;
  assign bus.Sample_valid = valid_q;
  assign bus.Noise_err    = noise_q;
  assign bus.Cfg_err      = cfg_err;

endmodule

// File: tb/tb_oversample_voter.sv
// Directed bench for oversample_voter: three instances cover SAMPLES=3/5 and SYNC_STAGES=2/3.
// Decisions are predicted into per-instance queues and checked when Sample_valid pulses.
module tb_oversample_voter;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] p, ec;
  logic          rx;
  logic [2:0]    en;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] qc[$];

  always #5 clk = ~clk;

  oversample_voter_if #(.PRESCALE_W(PW)) ifa ();
  oversample_voter_if #(.PRESCALE_W(PW)) ifb ();
  oversample_voter_if #(.PRESCALE_W(PW)) ifc ();

  assign ifa.Prescale = p;  assign ifa.Edge_count = ec;  assign ifa.RX_IN = rx;
  assign ifb.Prescale = p;  assign ifb.Edge_count = ec;  assign ifb.RX_IN = rx;
  assign ifc.Prescale = p;  assign ifc.Edge_count = ec;  assign ifc.RX_IN = rx;
  assign ifa.Sample_en = en[0];
  assign ifb.Sample_en = en[1];
  assign ifc.Sample_en = en[2];

  oversample_voter #(.PRESCALE_W(PW), .SAMPLES(3), .SYNC_STAGES(2)) u_a (
    .Clk(clk), .Rst(rst), .bus(ifa.slave)
  );
  oversample_voter #(.PRESCALE_W(PW), .SAMPLES(5), .SYNC_STAGES(2)) u_b (
    .Clk(clk), .Rst(rst), .bus(ifb.slave)
  );
  oversample_voter #(.PRESCALE_W(PW), .SAMPLES(3), .SYNC_STAGES(3)) u_c (
    .Clk(clk), .Rst(rst), .bus(ifc.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic b, input logic nz);
    case (d)
      0:       qa.push_back({b, nz});
      1:       qb.push_back({b, nz});
      default: qc.push_back({b, nz});
    endcase
  endtask

  // Every Sample_valid must match the oldest outstanding prediction for that instance.
  task automatic mon();
    logic [1:0] e;
    if (ifa.Sample_valid) begin
      chk("valid_a_expected", 8'(qa.size() != 0), 8'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("decision_a", {6'b0, ifa.Sampled_bit, ifa.Noise_err}, {6'b0, e});
      end
    end
    if (ifb.Sample_valid) begin
      chk("valid_b_expected", 8'(qb.size() != 0), 8'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("decision_b", {6'b0, ifb.Sampled_bit, ifb.Noise_err}, {6'b0, e});
      end
    end
    if (ifc.Sample_valid) begin
      chk("valid_c_expected", 8'(qc.size() != 0), 8'd1);
      if (qc.size() != 0) begin
        e = qc.pop_front();
        chk("decision_c", {6'b0, ifc.Sampled_bit, ifc.Noise_err}, {6'b0, e});
      end
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are examined on the falling edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = '0;
    ec = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One bit period; RX_IN is driven `sync` cycles ahead so rx_s shows pat at lo..lo+n-1.
  task automatic run_bit(input int d, input int ps, input int lo, input int sync,
                         input logic [4:0] pat, input int drop, input bit expv,
                         input logic eb, input logic enz);
    int n;
    int t;
    n = (d == 1) ? 5 : 3;
    if (expv) push(d, eb, enz);
    p = PW'(ps);
    for (int e = 0; e < ps; e++) begin
      t     = (e + sync) % ps;
      rx    = (t >= lo && t < lo + n) ? pat[t-lo] : 1'b1;
      ec    = PW'(e);
      en    = '0;
      en[d] = (e != drop);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    p   = PW'(8);
    ec  = '0;
    rx  = 1'b1;
    en  = '0;
    @(posedge clk);
    #1;
    chk("reset_a", {4'b0, ifa.Sampled_bit, ifa.Sample_valid, ifa.Noise_err, ifa.Cfg_err}, 8'h8);
    chk("reset_b", {4'b0, ifb.Sampled_bit, ifb.Sample_valid, ifb.Noise_err, ifb.Cfg_err}, 8'h8);
    chk("reset_c", {4'b0, ifc.Sampled_bit, ifc.Sample_valid, ifc.Noise_err, ifc.Cfg_err}, 8'h8);
    rst = 1'b0;
    idle(3);

    // Prescale 8, window 3..5.
    run_bit(0, 8, 3, 2, 5'b00101, -1, 1'b1, 1'b1, 1'b1);
    run_bit(0, 8, 3, 2, 5'b00000, -1, 1'b1, 1'b0, 1'b0);
    run_bit(0, 8, 3, 2, 5'b00111, -1, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("hold_bit_a", {7'b0, ifa.Sampled_bit}, 8'd1);
    chk("hold_noise_a", {7'b0, ifa.Noise_err}, 8'd0);

    // Configuration boundaries for 3 and 5 votes.
    p = PW'(3); #1;
    chk("cfg_a_p3", {7'b0, ifa.Cfg_err}, 8'd1);
    p = PW'(4); #1;
    chk("cfg_a_p4", {7'b0, ifa.Cfg_err}, 8'd0);
    p = PW'(5); #1;
    chk("cfg_b_p5", {7'b0, ifb.Cfg_err}, 8'd1);
    p = PW'(6); #1;
    chk("cfg_b_p6", {7'b0, ifb.Cfg_err}, 8'd0);

    for (int r = 0; r < 4; r++) run_bit(0, 3, 0, 2, 5'b00000, -1, 1'b0, 1'b0, 1'b0);
    run_bit(0, 4, 1, 2, 5'b00000, -1, 1'b1, 1'b0, 1'b0);
    run_bit(0, 4, 1, 2, 5'b00000, -1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("drain_a_cfg", 8'(qa.size()), 8'd0);

    // Prescale 16, window 7..9; an enable drop discards the bit.
    run_bit(0, 16, 7, 2, 5'b00111, 8, 1'b0, 1'b0, 1'b0);
    run_bit(0, 16, 7, 2, 5'b00100, -1, 1'b1, 1'b0, 1'b1);

    // Reset after one vote of a window.
    run_bit(0, 8, 3, 2, 5'b00010, -1, 1'b1, 1'b0, 1'b1);
    p = PW'(8);
    for (int e = 0; e < 8; e++) begin
      ec = PW'(e);
      rx = 1'b0;
      en = 3'b001;
      if (e == 4) begin
        rst = 1'b1;
        #1;
        chk("mid_reset_a", {5'b0, ifa.Sampled_bit, ifa.Sample_valid, ifa.Noise_err}, 8'h4);
        rst = 1'b0;
      end
      tick();
    end
    chk("post_reset_hold_a", {7'b0, ifa.Sampled_bit}, 8'd1);
    run_bit(0, 8, 3, 2, 5'b00110, -1, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("drain_a", 8'(qa.size()), 8'd0);

    // Five votes, Prescale 32, window 14..18.
    run_bit(1, 32, 14, 2, 5'b00000, -1, 1'b1, 1'b0, 1'b0);
    run_bit(1, 32, 14, 2, 5'b00011, -1, 1'b1, 1'b0, 1'b1);
    run_bit(1, 32, 14, 2, 5'b01101, -1, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("drain_b", 8'(qb.size()), 8'd0);

    // Three-stage synchroniser latency, then one decision through it.
    p  = PW'(8);
    rx = 1'b1;
    idle(4);
    chk("sync_c_idle", {7'b0, u_c.rx_s}, 8'd1);
    rx = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sync_c_k%0d", k), {7'b0, u_c.rx_s}, (k >= 3) ? 8'd0 : 8'd1);
      tick();
    end
    run_bit(2, 8, 3, 3, 5'b00001, -1, 1'b1, 1'b0, 1'b1);
    idle(2);
    chk("drain_c", 8'(qc.size()), 8'd0);
    chk("drain_a_final", 8'(qa.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
